// File: rtl/parametric_arb_mux.sv
// parametric_arb_mux: registered packet-aware N-to-1 stream mux with internal round-robin/fixed-priority arbitration
// Ports: CLK/RST (async active-high); VALID_IN/DATA_IN/LAST_IN/READY_OUT per input channel;
// VALID_OUT/DATA_OUT/LAST_OUT/SEL_OUT registered output stream with READY_IN backpressure;
// LOCKED_OUT high while a grant is held mid-packet.
module parametric_arb_mux #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8,
  parameter int ARB_MODE = 0,
  parameter int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_INPUTS-1:0] VALID_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] LAST_IN,
  output logic [NUM_INPUTS-1:0] READY_OUT,
  output logic                  VALID_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  LAST_OUT,
  output logic [SEL_WIDTH-1:0]  SEL_OUT,
  input  logic                  READY_IN,
  output logic                  LOCKED_OUT
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [SEL_WIDTH-1:0] gnt, last_gnt, pick, cur, idx;
  logic found, has_cur, out_free, xfer;
  int base;
  // Scan starts just past the last finished packet's channel (round-robin) or at 0 (fixed priority)
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = '0;
    base = ARB_MODE == 1 ? 0 : int'(last_gnt) + 1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = SEL_WIDTH'((base + k) % NUM_INPUTS);
      if (!found && VALID_IN[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign cur = state == LOCKED ? gnt : pick;
  assign has_cur = state == LOCKED || |VALID_IN;
  assign out_free = !VALID_OUT || READY_IN;
  assign xfer = out_free && has_cur && VALID_IN[cur];
  assign READY_OUT = (out_free && has_cur && !RST) ? NUM_INPUTS'(1) << cur : '0;
  assign LOCKED_OUT = state == LOCKED;
  always_comb begin
    state_n = state;
    if (xfer) state_n = LAST_IN[cur] ? IDLE : LOCKED;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VALID_OUT <= 1'b0;
      DATA_OUT <= '0;
      LAST_OUT <= 1'b0;
      SEL_OUT <= '0;
      gnt <= '0;
      last_gnt <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else if (xfer) begin
      VALID_OUT <= 1'b1;
      DATA_OUT <= DATA_IN[cur];
      LAST_OUT <= LAST_IN[cur];
      SEL_OUT <= cur;
      if (LAST_IN[cur]) last_gnt <= cur;
      else gnt <= cur;
    end else if (out_free) begin
      VALID_OUT <= 1'b0;
    end
  end
endmodule
